// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared ISA definitions for the fetch front-end and the Control decoder.
//   - OPC_W            : micro-op opcode width
//   - OPC_*            : architectural / micro-op opcode encodings
//   - OPC_RESET        : opcode presented while nothing valid is issued (NOP)
//   - opcodeLsb()      : LSB of the opcode field inside an instruction word;
//                        the opcode occupies word[INSTR_W-1 -: OPC_W]
//   - fetchState_t     : fetch/issue FSM state encoding
// Opcodes 010110..011011 (GPU group) are only legal when INSTR_GPU_OPS_EN is
// defined; the encodings live here unconditionally so Control can share them.
// -----------------------------------------------------------------------------
package isa_pkg;

  localparam int OPC_W = 6;

  // Multi-cycle memory instructions and their expansion steps.
  localparam logic [OPC_W-1:0] OPC_LW_1 = 6'b000000;
  localparam logic [OPC_W-1:0] OPC_LW_2 = 6'b000001;
  localparam logic [OPC_W-1:0] OPC_LW_3 = 6'b000010;
  localparam logic [OPC_W-1:0] OPC_SW_1 = 6'b000011;
  localparam logic [OPC_W-1:0] OPC_SW_2 = 6'b000100;
  localparam logic [OPC_W-1:0] OPC_ADD  = 6'b000110;
  // Highest base-ISA opcode; everything above it is the optional GPU group.
  localparam logic [OPC_W-1:0] OPC_NOP  = 6'b010101;

  // GPU group.
  localparam logic [OPC_W-1:0] OPC_SPRITE_LEVEL        = 6'b010110;
  localparam logic [OPC_W-1:0] OPC_SPRITE_POS          = 6'b010111;
  localparam logic [OPC_W-1:0] OPC_SPRITE_COLLISION_BG = 6'b011000;
  localparam logic [OPC_W-1:0] OPC_SPRITE_COLLISION_SP = 6'b011001;
  localparam logic [OPC_W-1:0] OPC_PUT_IMAGE           = 6'b011010;
  localparam logic [OPC_W-1:0] OPC_WAIT_VSYNC          = 6'b011011;

  localparam logic [OPC_W-1:0] OPC_RESET = OPC_NOP;

  function automatic int opcodeLsb(input int instrW);
    return instrW - OPC_W;
  endfunction

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_DRAIN = 2'd3
  } fetchState_t;

endpackage

// File: rtl/uop_expander.sv
// -----------------------------------------------------------------------------
// uop_expander
// Combinational micro-op expansion table.
//   op        in  : opcode of a fetched word, or the micro-op currently issued
//   first_uop out : first micro-op of the word (NOP for illegal words)
//   next_uop  out : micro-op following op within its expansion
//   is_last   out : op is the final micro-op of its expansion
//   illegal   out : op is not a legal architectural opcode
// Build option: INSTR_GPU_OPS_EN makes opcodes 010110..011011 legal
// single micro-ops; without it they are illegal and collapse to NOP.
// -----------------------------------------------------------------------------
module uop_expander
  import isa_pkg::*;
(
  input  logic [OPC_W-1:0] op,
  output logic [OPC_W-1:0] first_uop,
  output logic [OPC_W-1:0] next_uop,
  output logic             is_last,
  output logic             illegal
);

  always_comb begin
    illegal   = 1'b0;
    next_uop  = OPC_NOP;
    is_last   = 1'b1;

    // Continuation micro-ops must never appear in an architectural word.
    if (op == OPC_LW_2 || op == OPC_LW_3 || op == OPC_SW_2) begin
      illegal = 1'b1;
    end
`ifdef INSTR_GPU_OPS_EN
    else if (op > OPC_WAIT_VSYNC) begin
      illegal = 1'b1;
    end
`else
    else if (op > OPC_NOP) begin
      illegal = 1'b1;
    end
`endif

    first_uop = illegal ? OPC_NOP : op;

    // Successor table when op is the micro-op currently being issued.
    case (op)
      OPC_LW_1: begin next_uop = OPC_LW_2; is_last = 1'b0; end
      OPC_LW_2: begin next_uop = OPC_LW_3; is_last = 1'b0; end
      OPC_SW_1: begin next_uop = OPC_SW_2; is_last = 1'b0; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// instr_fetch_sequencer
// Fetch front-end ahead of Control: fetches words over a variable-latency
// request/valid handshake, holds them in the instruction register, owns the PC
// and issues a micro-op stream (LW -> 3 uops, SW -> 2 uops) with stall and
// branch-redirect handling.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   imem_addr/imem_rd       fetch address / one-cycle request pulse
//   imem_rdata/imem_valid   fetch response
//   stall                   downstream hold (branch_taken has priority)
//   branch_taken/_target    redirect request and address
//   pc_out                  address of the instruction being issued
//   instr                   instruction register (operand fields)
//   opcode                  micro-op to Control (NOP when instr_valid=0)
//   instr_valid             opcode/instr meaningful this cycle
// Build option: INSTR_GPU_OPS_EN (see uop_expander).
// -----------------------------------------------------------------------------
module instr_fetch_sequencer
  import isa_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] instr,
  output logic [OPC_W-1:0]   opcode,
  output logic               instr_valid
);

  localparam int OPC_LSB = opcodeLsb(INSTR_W);

  fetchState_t        stateReg, stateNext;
  logic [ADDR_W-1:0]  pcReg, pcNext;
  logic [ADDR_W-1:0]  pcOutReg, pcOutNext;
  logic [INSTR_W-1:0] instrReg, instrNext;
  logic [OPC_W-1:0]   uopReg, uopNext;

  logic [OPC_W-1:0]   expOp, expFirst, expNextUop;
  logic               expIsLast, expIllegal;

  // One expander serves both uses: in S_WAIT it decodes the arriving word,
  // otherwise it steps the micro-op currently held in uopReg.
  assign expOp = (stateReg == S_WAIT) ? imem_rdata[OPC_LSB +: OPC_W] : uopReg;

  uop_expander uExpander (
    .op        (expOp),
    .first_uop (expFirst),
    .next_uop  (expNextUop),
    .is_last   (expIsLast),
    .illegal   (expIllegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= S_REQ;
      pcReg    <= RESET_PC;
      pcOutReg <= RESET_PC;
      instrReg <= '0;
      uopReg   <= OPC_RESET;
    end else begin
      stateReg <= stateNext;
      pcReg    <= pcNext;
      pcOutReg <= pcOutNext;
      instrReg <= instrNext;
      uopReg   <= uopNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    pcNext      = pcReg;
    pcOutNext   = pcOutReg;
    instrNext   = instrReg;
    uopNext     = uopReg;
    imem_rd     = 1'b0;
    instr_valid = 1'b0;

    case (stateReg)
      S_REQ: begin
        // The state register sits in S_REQ throughout reset; keep the request
        // quiet until reset is released.
        imem_rd = rst_n;
        if (branch_taken) begin
          // The request still goes out this cycle, so its response must be
          // drained before fetching from the new target.
          pcNext    = branch_target;
          stateNext = S_DRAIN;
        end else begin
          stateNext = S_WAIT;
        end
      end

      S_WAIT: begin
        if (branch_taken) begin
          pcNext    = branch_target;
          stateNext = imem_valid ? S_REQ : S_DRAIN;
        end else if (imem_valid) begin
          instrNext = imem_rdata;
          pcOutNext = pcReg;
          pcNext    = pcReg + ADDR_W'(1);
          uopNext   = expIllegal ? OPC_NOP : expFirst;
          stateNext = S_ISSUE;
        end
      end

      S_ISSUE: begin
        instr_valid = 1'b1;
        if (branch_taken) begin
          // Remaining micro-ops of this instruction are dropped.
          pcNext    = branch_target;
          stateNext = S_REQ;
        end else if (!stall) begin
          if (expIsLast) begin
            stateNext = S_REQ;
          end else begin
            uopNext = expNextUop;
          end
        end
      end

      S_DRAIN: begin
        if (branch_taken) begin
          pcNext = branch_target;
        end
        if (imem_valid) begin
          stateNext = S_REQ;
        end
      end

      default: stateNext = S_REQ;
    endcase
  end

  assign imem_addr = pcReg;
  assign pc_out    = pcOutReg;
  assign instr     = instrReg;
  assign opcode    = instr_valid ? uopReg : OPC_NOP;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_sequencer
// Directed program run against a behavioural memory and a transaction-level
// model: the model lists, per fetched word, the request address and the
// micro-ops that must be issued (from the expansion rules), and a per-cycle
// compare process checks every request and every issue cycle against it.
// Literal expectations pin reset values and per-opcode issue-cycle counts.
// -----------------------------------------------------------------------------
module tb_instr_fetch_sequencer;

  localparam logic [5:0] LW1 = 6'b000000;
  localparam logic [5:0] LW2 = 6'b000001;
  localparam logic [5:0] LW3 = 6'b000010;
  localparam logic [5:0] SW1 = 6'b000011;
  localparam logic [5:0] SW2 = 6'b000100;
  localparam logic [5:0] ADD = 6'b000110;
  localparam logic [5:0] NOP = 6'b010101;
  localparam logic [5:0] PUTIMG = 6'b011010;
`ifdef INSTR_GPU_OPS_EN
  localparam bit GPU_EN = 1'b1;
`else
  localparam bit GPU_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = '0;
  logic [15:0] pc_out;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] pc;
    logic [5:0]  op;
    logic [31:0] word;
  } iss_t;

  iss_t        expIss[$];
  logic [15:0] expReq[$];
  int          opCnt[64];
  bit          chk = 1'b0;

  instr_fetch_sequencer #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rd       (imem_rd),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_out        (pc_out),
    .instr         (instr),
    .opcode        (opcode),
    .instr_valid   (instr_valid)
  );

  always #5 clk = ~clk;

  // Program image.
  function automatic logic [31:0] memWord(input logic [15:0] a);
    case (a)
      16'h0000: return {ADD,       26'hA1};
      16'h0001: return {SW1,       26'h12345};
      16'h0002: return {6'b000001, 26'h2};
      16'h0003: return {6'b011111, 26'h3};
      16'h0004: return {PUTIMG,    26'h4};
      16'h0005: return {LW1,       26'h55};
      16'h0006: return {LW1,       26'h66};
      default:  return {ADD, 10'd0, a};
    endcase
  endfunction

  // Response latency in cycles after the request cycle.
  function automatic int latOf(input logic [15:0] a);
    if (a == 16'h0000) return 2;
    if (a == 16'h0021) return 3;
    return 1;
  endfunction

  // Model: expected request plus the first 'keep' micro-ops of the word.
  task automatic pushWord(input logic [15:0] a, input int keep);
    logic [31:0] w;
    logic [5:0]  op;
    logic [5:0]  seq[$];
    iss_t        e;
    w  = memWord(a);
    op = w[31:26];
    if (op == LW1)                              seq = '{LW1, LW2, LW3};
    else if (op == SW1)                         seq = '{SW1, SW2};
    else if (op == LW2 || op == LW3 || op == SW2) seq = '{NOP};
    else if (op > 6'd27 || (op > NOP && !GPU_EN)) seq = '{NOP};
    else                                        seq = '{op};
    expReq.push_back(a);
    for (int i = 0; i < seq.size() && i < keep; i++) begin
      e.pc = a; e.op = seq[i]; e.word = w;
      expIss.push_back(e);
    end
  endtask

  // Memory responder.
  bit          rdSeen = 1'b0;
  logic [15:0] addrSeen = '0;
  logic [15:0] pendAddr = '0;
  int          pendCnt = 0;

  always @(negedge clk) begin
    rdSeen   = imem_rd;
    addrSeen = imem_addr;
  end

  always @(posedge clk) begin
    #1;
    imem_valid = 1'b0;
    if (!rst_n) begin
      pendCnt = 0;
      rdSeen  = 1'b0;
    end else begin
      if (pendCnt > 0) begin
        pendCnt--;
        if (pendCnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = memWord(pendAddr);
        end
      end
      if (rdSeen) begin
        pendAddr = addrSeen;
        if (latOf(addrSeen) == 1) begin
          imem_valid = 1'b1;
          imem_rdata = memWord(addrSeen);
        end else begin
          pendCnt = latOf(addrSeen) - 1;
        end
        rdSeen = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    iss_t e;
    logic [15:0] r;
    if (chk) begin
      if (imem_rd === 1'b1) begin
        checks++;
        if (expReq.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected addr=%h expected no request", imem_addr);
        end else begin
          r = expReq.pop_front();
          if (imem_addr !== r) begin
            errors++;
            $display("FAIL req_addr got %h expected %h", imem_addr, r);
          end else
            $display("req   addr=%h", imem_addr);
        end
      end
      if (instr_valid === 1'b1) begin
        opCnt[opcode]++;
        checks++;
        if (expIss.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected op=%b pc=%h", opcode, pc_out);
        end else begin
          e = expIss[0];
          if (opcode !== e.op || pc_out !== e.pc || instr !== e.word) begin
            errors++;
            $display("FAIL issue got op=%b pc=%h instr=%h expected op=%b pc=%h instr=%h",
                     opcode, pc_out, instr, e.op, e.pc, e.word);
          end else
            $display("issue op=%b pc=%h instr=%h stall=%0b br=%0b",
                     opcode, pc_out, instr, stall, branch_taken);
          if (!stall || branch_taken) void'(expIss.pop_front());
        end
      end else begin
        checks++;
        if (opcode !== NOP) begin
          errors++;
          $display("FAIL idle_opcode got %b expected %b", opcode, NOP);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkEq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end else
      $display("check %s = %h", name, got);
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return instr_valid === 1'b1 && opcode === SW1;
      1:       return instr_valid === 1'b1 && opcode === LW2 && pc_out === 16'h0006;
      2:       return imem_rd === 1'b1 && imem_addr === 16'h0021;
      default: return expIss.size() == 0;
    endcase
  endfunction

  task automatic waitCond(input int which, input string name);
    int n;
    n = 0;
    while (!cond(which) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (!cond(which)) begin
      errors++;
      $display("FAIL timeout_%s got no event in %0d cycles expected event", name, n);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkEq("reset_imem_rd",     32'(imem_rd), 32'd0);
    checkEq("reset_instr_valid", 32'(instr_valid), 32'd0);
    checkEq("reset_opcode",      32'(opcode), 32'(NOP));
    checkEq("reset_pc_out",      32'(pc_out), 32'h0);
    checkEq("reset_instr",       instr, 32'h0);

    pushWord(16'h0000, 9);
    pushWord(16'h0001, 9);
    pushWord(16'h0002, 9);
    pushWord(16'h0003, 9);
    pushWord(16'h0004, 9);
    pushWord(16'h0005, 9);
    pushWord(16'h0006, 2);   // branch lands during LW_2: LW_3 aborted
    pushWord(16'h0020, 9);
    pushWord(16'h0021, 0);   // redirected while waiting: nothing issues
    pushWord(16'h0040, 9);

    chk   = 1'b1;
    rst_n = 1'b1;

    // SW_1 stalled for three cycles.
    waitCond(0, "sw1");
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;

    // Branch together with stall during LW_2 of the word at 6.
    waitCond(1, "lw2");
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 16'h0020;
    tick();
    stall         = 1'b0;
    branch_taken  = 1'b0;

    // Branch in S_WAIT while the response for 0x21 is still outstanding.
    waitCond(2, "req21");
    tick();
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    tick();
    branch_taken  = 1'b0;

    waitCond(3, "drain");
    chk = 1'b0;

    checkEq("req_queue_left", 32'(expReq.size()), 32'd0);
    checkEq("cnt_lw1", 32'(opCnt[LW1]), 32'd2);
    checkEq("cnt_lw2", 32'(opCnt[LW2]), 32'd2);
    checkEq("cnt_lw3", 32'(opCnt[LW3]), 32'd1);
    checkEq("cnt_sw1", 32'(opCnt[SW1]), 32'd4);
    checkEq("cnt_sw2", 32'(opCnt[SW2]), 32'd1);
    checkEq("cnt_add", 32'(opCnt[ADD]), 32'd3);
    checkEq("cnt_nop", 32'(opCnt[NOP]), GPU_EN ? 32'd2 : 32'd3);
    checkEq("cnt_putimg", 32'(opCnt[PUTIMG]), GPU_EN ? 32'd1 : 32'd0);

    // Asynchronous reset mid-run, checked before any clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    checkEq("areset_imem_rd",     32'(imem_rd), 32'd0);
    checkEq("areset_instr_valid", 32'(instr_valid), 32'd0);
    checkEq("areset_opcode",      32'(opcode), 32'(NOP));
    checkEq("areset_pc_out",      32'(pc_out), 32'h0);
    checkEq("areset_imem_addr",   32'(imem_addr), 32'h0);
    checkEq("areset_instr",       instr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
